// File: rtl/regfile_pkg.sv
// Shared register-file types for the integer array, pipeline and writeback arbiter.
package regfile_pkg;

  localparam int XLEN          = 64;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_req_t;

  // One-hot mask for a register index; x0 never produces a bit.
  function automatic logic [NUM_ARCH_REGS-1:0] reg_bit(input reg_idx_t idx);
    logic [NUM_ARCH_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// Simulation checks for the writeback arbiter: WAW issue and retire-without-producer.
module regfile_wb_arbiter_chk
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  input logic [NUM_REQ-1:0]        req_valid_i,
  input logic [NUM_REQ-1:0]        req_ready_i,
  input logic [NUM_REQ*ADDR_W-1:0] req_rd_i,
  input logic                      issue_valid_i,
  input logic [ADDR_W-1:0]         issue_rd_i,
  input logic [NUM_ARCH_REGS-1:0]  pending_i
);

  logic [NUM_ARCH_REGS-1:0] clr_s;

  // Registers retiring this cycle; a same-cycle re-issue of these is legal.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      clr_s = clr_s | (reg_bit(reg_idx_t'(req_rd_i[i*ADDR_W +: ADDR_W]))
                       & {NUM_ARCH_REGS{req_valid_i[i] & req_ready_i[i]}});
    end
  end

  a_no_waw_issue: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (issue_valid_i && issue_rd_i != '0) |-> (!pending_i[issue_rd_i] || clr_s[issue_rd_i]));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wb_chk
    a_wb_has_producer: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (req_valid_i[gi] && req_ready_i[gi] && req_rd_i[gi*ADDR_W +: ADDR_W] != '0)
        |-> pending_i[req_rd_i[gi*ADDR_W +: ADDR_W]])
      else $warning("writeback to x%0d with no pending producer", req_rd_i[gi*ADDR_W +: ADDR_W]);
  end

endmodule

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Writeback grant arbiter: round-robin by default, lowest-index-first when
// WB_ARB_FIXED_PRIO_EN is defined (no pointer state in that build).
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifdef WB_ARB_FIXED_PRIO_EN

  logic unused_s;
  logic found_s;

  assign unused_s = clk_i ^ rst_n_i;

  // Lowest asserted index wins.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req_i[k]) begin
        grant_o[k] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`else

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_s;
  logic             found_s;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W-1:0] off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) begin
      sum = sum - (PTR_W+1)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Scan from the pointer, wrapping, and take the first requester found.
  always_comb begin
    grant_o = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req_i[wrap_add(ptr_q, PTR_W'(k))]) begin
        found_s         = 1'b1;
        gidx_s          = wrap_add(ptr_q, PTR_W'(k));
        grant_o[gidx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    ptr_d = found_s ? wrap_add(gidx_s, PTR_W'(1)) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-array write port
// and tracks per-register pending writes. WB_ARB_FIXED_PRIO_EN selects fixed priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  output logic                      wb_valid_o,
  output logic [ADDR_W-1:0]         wb_rd_o,
  output logic [DATA_W-1:0]         wb_data_o,
  output logic [NUM_ARCH_REGS-1:0]  pending_o
);

  logic [NUM_REQ-1:0]       grant_s;
  logic                     hs_s;
  logic                     wr_s;
  logic [ADDR_W-1:0]        hs_rd_s;
  logic [DATA_W-1:0]        hs_data_s;
  logic [NUM_ARCH_REGS-1:0] set_mask_s, clr_mask_s;

  logic                     wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]        wb_data_q, wb_data_d;
  logic [NUM_ARCH_REGS-1:0] pending_q, pending_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (req_valid_i),
    .grant_o (grant_s)
  );

  assign req_ready_o = grant_s & {NUM_REQ{rst_n_i}};
  assign hs_s        = |grant_s;

  // Grant is one-hot, so an AND-OR mux selects the winner's payload.
  always_comb begin
    hs_rd_s   = '0;
    hs_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hs_rd_s   = hs_rd_s   | (req_rd_i[i*ADDR_W +: ADDR_W]   & {ADDR_W{grant_s[i]}});
      hs_data_s = hs_data_s | (req_data_i[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  assign wr_s = hs_s && (hs_rd_s != '0);

  // Next write-port and scoreboard state; a set is applied after the clear so it wins.
  always_comb begin
    wb_valid_d = wr_s;
    if (wr_s) begin
      wb_rd_d   = hs_rd_s;
      wb_data_d = hs_data_s;
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
    clr_mask_s = wr_s          ? reg_bit(reg_idx_t'(hs_rd_s))    : '0;
    set_mask_s = issue_valid_i ? reg_bit(reg_idx_t'(issue_rd_i)) : '0;
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      pending_q  <= pending_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign pending_o  = pending_q;

endmodule
